// File: rtl/lcu_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined lookahead carry unit.
// Topology selectors, level/stage counts and the Sklansky source index live here.
package lcu_pkg;

    localparam int ARCH_KS = 0;
    localparam int ARCH_SK = 1;

    // Number of prefix levels: ceil(log2(width)), zero for a single bit.
    function automatic int lcu_levels(input int width);
        int lv;
        lv = 0;
        while ((1 << lv) < width) lv++;
        return lv;
    endfunction

    // At least one register stage is always present, even with no prefix levels.
    function automatic int lcu_stages(input int width, input int lpr);
        int lv;
        lv = lcu_levels(width);
        return (lv == 0) ? 1 : (lv + lpr - 1) / lpr;
    endfunction

    function automatic int sk_src(input int j, input int i);
        return ((j >> (i + 1)) << (i + 1)) + (1 << i) - 1;
    endfunction

endpackage

// File: rtl/lcu_prefix_slice.sv
// Combinational group of prefix levels [LO, HI) applied to a {g, p} vector.
// Each level reads only the previous level's outputs; untouched positions pass through.
module lcu_prefix_slice
    import lcu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ARCH  = 0,
    parameter int LO    = 0,
    parameter int HI    = 0
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);

    if (HI > LO) begin : g_levels
        for (genvar i = LO; i < HI; i++) begin : g_lv
            localparam int S = 1 << i;

            logic [WIDTH-1:0] g_d;
            logic [WIDTH-1:0] p_d;
            logic [WIDTH-1:0] g_q;
            logic [WIDTH-1:0] p_q;

            if (i == LO) begin : g_src_in
                assign g_d = g_in;
                assign p_d = p_in;
            end else begin : g_src_prev
                assign g_d = g_lv[i-1].g_q;
                assign p_d = g_lv[i-1].p_q;
            end

            // Source index is resolved at elaboration; out-of-range sources fall to pass-through.
            for (genvar j = 0; j < WIDTH; j++) begin : g_bit
                if (ARCH == ARCH_KS && j >= S) begin : g_ks
                    assign g_q[j] = g_d[j] | (p_d[j] & g_d[j-S]);
                    assign p_q[j] = p_d[j] & p_d[j-S];
                end else if (ARCH == ARCH_SK && ((j >> i) & 1) == 1 && sk_src(j, i) < WIDTH) begin : g_sk
                    assign g_q[j] = g_d[j] | (p_d[j] & g_d[sk_src(j, i)]);
                    assign p_q[j] = p_d[j] & p_d[sk_src(j, i)];
                end else begin : g_pass
                    assign g_q[j] = g_d[j];
                    assign p_q[j] = p_d[j];
                end
            end
        end

        assign g_out = g_lv[HI-1].g_q;
        assign p_out = g_lv[HI-1].p_q;
    end else begin : g_bypass
        assign g_out = g_in;
        assign p_out = p_in;
    end

endmodule

// File: rtl/lcu_prefix_pipelined.sv
// Pipelined lookahead carry unit: prefix levels split into register stages with a
// valid/ready handshake, per-stage backpressure and a sideband tag.
module lcu_prefix_pipelined
    import lcu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ARCH  = 0,
    parameter int LPR   = 2,
    parameter int TAG_W = 4
) (
    input  logic             CLK,
    input  logic             ARST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] P,
    input  logic [WIDTH-1:0] G,
    input  logic             CI,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] CO,
    output logic [WIDTH-1:0] PO,
    output logic [TAG_W-1:0] OUT_TAG
);

    localparam int LV = lcu_levels(WIDTH);
    localparam int NS = lcu_stages(WIDTH, LPR);

    if (WIDTH < 1 || LPR < 1 || TAG_W < 1) begin : g_bad_param
        $error("lcu_prefix_pipelined: WIDTH, LPR and TAG_W must all be >= 1");
    end

    if (ARCH != ARCH_KS && ARCH != ARCH_SK) begin : g_bad_arch
        $error("lcu_prefix_pipelined: ARCH must be 0 (Kogge-Stone) or 1 (Sklansky)");
    end

    logic             v_q    [NS];
    logic [WIDTH-1:0] g_q    [NS];
    logic [WIDTH-1:0] p_q    [NS];
    logic [TAG_W-1:0] tag_q  [NS];

    logic             up_v   [NS];
    logic [WIDTH-1:0] up_g   [NS];
    logic [WIDTH-1:0] up_p   [NS];
    logic [TAG_W-1:0] up_tag [NS];
    logic [WIDTH-1:0] nx_g   [NS];
    logic [WIDTH-1:0] nx_p   [NS];
    logic             rdy    [NS+1];

    logic [WIDTH-1:0] g_ci;

    // Carry-in folds into bit 0 only; after that it behaves like an ordinary generate.
    always_comb begin
        g_ci    = G;
        g_ci[0] = G[0] | (P[0] & CI);
    end

    for (genvar k = 0; k < NS; k++) begin : g_stage
        localparam int LO = (k * LPR < LV) ? k * LPR : LV;
        localparam int HI = ((k + 1) * LPR < LV) ? (k + 1) * LPR : LV;

        if (k == 0) begin : g_head
            assign up_v[k]   = IN_VALID;
            assign up_g[k]   = g_ci;
            assign up_p[k]   = P;
            assign up_tag[k] = IN_TAG;
        end else begin : g_body
            assign up_v[k]   = v_q[k-1];
            assign up_g[k]   = g_q[k-1];
            assign up_p[k]   = p_q[k-1];
            assign up_tag[k] = tag_q[k-1];
        end

        lcu_prefix_slice #(
            .WIDTH (WIDTH),
            .ARCH  (ARCH),
            .LO    (LO),
            .HI    (HI)
        ) u_slice (
            .g_in  (up_g[k]),
            .p_in  (up_p[k]),
            .g_out (nx_g[k]),
            .p_out (nx_p[k])
        );
    end

    // An empty slot is always loadable, so bubbles collapse toward the output.
    always_comb begin
        rdy[NS] = OUT_READY;
        for (int k = NS - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
    end

    // Data flops only move when a real beat arrives; a bubble just clears the valid bit.
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            for (int k = 0; k < NS; k++) begin
                v_q[k]   <= 1'b0;
                g_q[k]   <= '0;
                p_q[k]   <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NS; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= up_v[k];
                    if (up_v[k]) begin
                        g_q[k]   <= nx_g[k];
                        p_q[k]   <= nx_p[k];
                        tag_q[k] <= up_tag[k];
                    end
                end
            end
        end
    end

    assign IN_READY  = rdy[0];
    assign OUT_VALID = v_q[NS-1];
    assign CO        = g_q[NS-1];
    assign PO        = p_q[NS-1];
    assign OUT_TAG   = tag_q[NS-1];

endmodule

// File: tb/tb_lcu_prefix_pipelined.sv
// Bench for lcu_prefix_pipelined: several configurations share stimulus, one is selected
// at a time and checked against a ripple-carry reference and an in-flight beat queue.
module tb_lcu_prefix_pipelined;

    logic        clk = 1'b0;
    logic        arst;
    logic        in_valid;
    logic        out_ready;
    logic        ci;
    logic [31:0] p_in;
    logic [31:0] g_in;
    logic [3:0]  tag_in;
    int          sel;

    int nCompared   = 0;
    int nMismatched = 0;

    logic        irdy [6];
    logic        ovld [6];
    logic [3:0]  otag [6];
    logic [7:0]  co0, po0, co1, po1;
    logic [0:0]  co2, po2;
    logic [12:0] co3, po3, co4, po4;
    logic [31:0] co5, po5;

    logic        obs_in_ready;
    logic        obs_out_valid;
    logic [31:0] obs_co;
    logic [31:0] obs_po;
    logic [3:0]  obs_tag;

    typedef struct {
        logic [31:0] co;
        logic [31:0] po;
        logic [3:0]  tag;
    } beat_t;

    beat_t q[$];

    always #5 clk = ~clk;

    lcu_prefix_pipelined #(.WIDTH(8), .ARCH(0), .LPR(1), .TAG_W(4)) u_w8_ks (
        .CLK(clk), .ARST(arst), .IN_VALID(in_valid && sel == 0), .IN_READY(irdy[0]),
        .P(p_in[7:0]), .G(g_in[7:0]), .CI(ci), .IN_TAG(tag_in),
        .OUT_VALID(ovld[0]), .OUT_READY(out_ready), .CO(co0), .PO(po0), .OUT_TAG(otag[0])
    );

    lcu_prefix_pipelined #(.WIDTH(8), .ARCH(1), .LPR(1), .TAG_W(4)) u_w8_sk (
        .CLK(clk), .ARST(arst), .IN_VALID(in_valid && sel == 1), .IN_READY(irdy[1]),
        .P(p_in[7:0]), .G(g_in[7:0]), .CI(ci), .IN_TAG(tag_in),
        .OUT_VALID(ovld[1]), .OUT_READY(out_ready), .CO(co1), .PO(po1), .OUT_TAG(otag[1])
    );

    lcu_prefix_pipelined #(.WIDTH(1), .ARCH(0), .LPR(3), .TAG_W(4)) u_w1 (
        .CLK(clk), .ARST(arst), .IN_VALID(in_valid && sel == 2), .IN_READY(irdy[2]),
        .P(p_in[0:0]), .G(g_in[0:0]), .CI(ci), .IN_TAG(tag_in),
        .OUT_VALID(ovld[2]), .OUT_READY(out_ready), .CO(co2), .PO(po2), .OUT_TAG(otag[2])
    );

    lcu_prefix_pipelined #(.WIDTH(13), .ARCH(0), .LPR(3), .TAG_W(4)) u_w13_ks (
        .CLK(clk), .ARST(arst), .IN_VALID(in_valid && sel == 3), .IN_READY(irdy[3]),
        .P(p_in[12:0]), .G(g_in[12:0]), .CI(ci), .IN_TAG(tag_in),
        .OUT_VALID(ovld[3]), .OUT_READY(out_ready), .CO(co3), .PO(po3), .OUT_TAG(otag[3])
    );

    lcu_prefix_pipelined #(.WIDTH(13), .ARCH(1), .LPR(3), .TAG_W(4)) u_w13_sk (
        .CLK(clk), .ARST(arst), .IN_VALID(in_valid && sel == 4), .IN_READY(irdy[4]),
        .P(p_in[12:0]), .G(g_in[12:0]), .CI(ci), .IN_TAG(tag_in),
        .OUT_VALID(ovld[4]), .OUT_READY(out_ready), .CO(co4), .PO(po4), .OUT_TAG(otag[4])
    );

    lcu_prefix_pipelined #(.WIDTH(32), .ARCH(0), .LPR(2), .TAG_W(4)) u_w32_ks (
        .CLK(clk), .ARST(arst), .IN_VALID(in_valid && sel == 5), .IN_READY(irdy[5]),
        .P(p_in), .G(g_in), .CI(ci), .IN_TAG(tag_in),
        .OUT_VALID(ovld[5]), .OUT_READY(out_ready), .CO(co5), .PO(po5), .OUT_TAG(otag[5])
    );

    // Route the selected instance onto one set of observation signals.
    always_comb begin
        obs_in_ready  = 1'b0;
        obs_out_valid = 1'b0;
        obs_co        = '0;
        obs_po        = '0;
        obs_tag       = '0;
        if (sel >= 0 && sel < 6) begin
            obs_in_ready  = irdy[sel];
            obs_out_valid = ovld[sel];
            obs_tag       = otag[sel];
        end
        case (sel)
            0: begin obs_co = {24'b0, co0}; obs_po = {24'b0, po0}; end
            1: begin obs_co = {24'b0, co1}; obs_po = {24'b0, po1}; end
            2: begin obs_co = {31'b0, co2}; obs_po = {31'b0, po2}; end
            3: begin obs_co = {19'b0, co3}; obs_po = {19'b0, po3}; end
            4: begin obs_co = {19'b0, co4}; obs_po = {19'b0, po4}; end
            5: begin obs_co = co5;          obs_po = po5;          end
            default: ;
        endcase
    end

    function automatic int widthOf(input int s);
        case (s)
            0, 1:    return 8;
            2:       return 1;
            3, 4:    return 13;
            default: return 32;
        endcase
    endfunction

    // Expected pipeline depth: ceil(ceil(log2 W) / LPR), never below one.
    function automatic int nsOf(input int s);
        case (s)
            0, 1:    return 3;
            2:       return 1;
            3, 4:    return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] maskOf(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Golden carries: a plain ripple chain starting from the carry-in.
    function automatic logic [31:0] refCarry(input logic [31:0] p, input logic [31:0] g,
                                             input logic c, input int w);
        logic [31:0] co;
        logic        cy;
        co = '0;
        cy = c;
        for (int j = 0; j < w; j++) begin
            cy    = g[j] | (p[j] & cy);
            co[j] = cy;
        end
        return co;
    endfunction

    function automatic logic [31:0] refProp(input logic [31:0] p, input int w);
        logic [31:0] po;
        logic        run;
        po  = '0;
        run = 1'b1;
        for (int j = 0; j < w; j++) begin
            run   = run & p[j];
            po[j] = run;
        end
        return po;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] p, input logic [31:0] g,
                                 input logic c, input logic [3:0] t, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        p_in      = p;
        g_in      = g;
        ci        = c;
        tag_in    = t;
        out_ready = ordy;
        #1;
    endtask

    task automatic resetDut();
        arst      = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        #1;
    endtask

    // One beat through an empty pipeline with OUT_READY held high; latency counted in cycles.
    task automatic runSingle(input int s, input logic [31:0] p, input logic [31:0] g, input logic c);
        int          lat;
        int          w;
        logic [31:0] co;
        logic [31:0] po;
        logic [3:0]  t;
        sel = s;
        w   = widthOf(s);
        lat = 0;
        co  = '0;
        po  = '0;
        t   = '0;
        applyStimulus(1'b1, p, g, c, 4'hA, 1'b1);
        checkOutput($sformatf("single_accept[%0d]", s), 32'(obs_in_ready), 32'd1);
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 4'h0, 1'b1);
            if (obs_out_valid) begin
                lat = n;
                co  = obs_co;
                po  = obs_po;
                t   = obs_tag;
            end
        end
        checkOutput($sformatf("latency[%0d]", s), 32'(lat), 32'(nsOf(s)));
        checkOutput($sformatf("single_co[%0d]", s), co, refCarry(p & maskOf(w), g & maskOf(w), c, w));
        checkOutput($sformatf("single_po[%0d]", s), po, refProp(p & maskOf(w), w));
        checkOutput($sformatf("single_tag[%0d]", s), 32'(t), 32'hA);
    endtask

    // Streams beats through one instance, scoreboarding every output cycle against the queue.
    task automatic runStream(input int s, input int nBeats, input bit pattern, input int budget);
        int          w, ns, sent, got, cyc;
        logic [31:0] m, bp, bg;
        logic        bc, v, r;
        beat_t       e;
        sel  = s;
        w    = widthOf(s);
        ns   = nsOf(s);
        m    = maskOf(w);
        sent = 0;
        got  = 0;
        cyc  = 0;
        q.delete();
        bp = $urandom() & m;
        bg = $urandom() & m;
        bc = 1'($urandom());
        while ((sent < nBeats || q.size() > 0) && cyc < budget) begin
            v = (sent < nBeats) && (pattern || $urandom_range(0, 3) != 0);
            r = pattern ? ((cyc % 4) == 0 || (cyc % 4) == 3) : ($urandom_range(0, 2) != 0);
            applyStimulus(v, bp, bg, bc, 4'(sent), r);
            checkOutput($sformatf("in_ready[%0d]", s), 32'(obs_in_ready),
                        32'((q.size() < ns) || r));
            if (q.size() == 0) begin
                checkOutput($sformatf("idle_valid[%0d]", s), 32'(obs_out_valid), 32'd0);
            end else if (obs_out_valid) begin
                checkOutput($sformatf("co[%0d]", s), obs_co, q[0].co);
                checkOutput($sformatf("po[%0d]", s), obs_po, q[0].po);
                checkOutput($sformatf("tag[%0d]", s), 32'(obs_tag), 32'(q[0].tag));
                if (r) begin
                    void'(q.pop_front());
                    got++;
                end
            end
            if (v && obs_in_ready) begin
                e.co  = refCarry(bp, bg, bc, w);
                e.po  = refProp(bp, w);
                e.tag = 4'(sent);
                q.push_back(e);
                sent++;
                bp = $urandom() & m;
                bg = $urandom() & m;
                bc = 1'($urandom());
            end
            cyc++;
        end
        checkOutput($sformatf("delivered[%0d]", s), 32'(got), 32'(nBeats));
    endtask

    initial begin
        int nSeen;
        sel       = 0;
        arst      = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        p_in      = '0;
        g_in      = '0;
        ci        = 1'b0;
        tag_in    = '0;

        resetDut();
        checkOutput("rst_out_valid", 32'(obs_out_valid), 32'd0);
        checkOutput("rst_co", obs_co, 32'd0);
        checkOutput("rst_po", obs_po, 32'd0);
        checkOutput("rst_tag", 32'(obs_tag), 32'd0);
        checkOutput("rst_in_ready", 32'(obs_in_ready), 32'd1);

        runSingle(0, 32'hFF, 32'h00, 1'b1);
        runSingle(1, 32'h0F, 32'h01, 1'b0);
        runSingle(0, 32'h0F, 32'h01, 1'b0);
        for (int s = 0; s < 6; s++) begin
            runSingle(s, $urandom(), $urandom(), 1'($urandom()));
        end

        resetDut();
        runStream(0, 16, 1'b1, 200);

        // Two beats in flight, then a one-cycle reset must wipe them out.
        resetDut();
        sel = 0;
        applyStimulus(1'b1, $urandom(), $urandom(), 1'b1, 4'h3, 1'b0);
        checkOutput("mid_accept0", 32'(obs_in_ready), 32'd1);
        applyStimulus(1'b1, $urandom(), $urandom(), 1'b0, 4'h4, 1'b0);
        checkOutput("mid_accept1", 32'(obs_in_ready), 32'd1);
        @(negedge clk);
        arst     = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(obs_out_valid), 32'd0);
        checkOutput("mid_rst_co", obs_co, 32'd0);
        @(negedge clk);
        arst = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", 32'(obs_in_ready), 32'd1);
        nSeen = 0;
        repeat (8) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 4'h0, 1'b1);
            if (obs_out_valid) nSeen++;
        end
        checkOutput("mid_rst_discard", 32'(nSeen), 32'd0);

        resetDut();
        runStream(2, 1000, 1'b0, 20000);
        resetDut();
        runStream(3, 1000, 1'b0, 20000);
        resetDut();
        runStream(4, 1000, 1'b0, 20000);
        resetDut();
        runStream(0, 300, 1'b0, 6000);
        resetDut();
        runStream(1, 300, 1'b0, 6000);
        resetDut();
        runStream(5, 300, 1'b0, 6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
